// File: rtl/gf_pkg.sv
// -----------------------------------------------------------------------------
// gf_pkg
// Shared GF(2^8) definitions for the discrete-log unit and its neighbours in
// the GF multiplier datapath.
//   GF_W      element width in bits
//   GF_POLY   field polynomial x^8+x^4+x^3+x^2+1
//   GF_ORDER  order of the multiplicative group (number of nonzero elements)
//   gf_elem_t one field element
//   gf_log_state_e  state encoding of the log search FSM
//   gf_div_x  multiply an element by x^-1 (one step backwards along the powers of x)
// -----------------------------------------------------------------------------
package gf_pkg;

    localparam int         GF_W     = 8;
    localparam logic [8:0] GF_POLY  = 9'h11D;
    localparam int         GF_ORDER = 255;

    typedef logic [GF_W-1:0] gf_elem_t;

    typedef enum logic [1:0] {
        GF_LOG_IDLE   = 2'd0,
        GF_LOG_SEARCH = 2'd1,
        GF_LOG_DONE   = 2'd2
    } gf_log_state_e;

    // Division by x: an odd element first has the polynomial added so the
    // constant term cancels, then the whole thing shifts down one degree.
    // The polynomial's x^8 term lands in bit 7 after the shift.
    function automatic gf_elem_t gf_div_x(gf_elem_t v, logic [8:0] poly);
        logic [8:0] t;
        t = {1'b0, v};
        if (v[0]) begin
            t = t ^ poly;
        end
        return t[8:1];
    endfunction

endpackage

// File: rtl/gf_log_seq_if.sv
// -----------------------------------------------------------------------------
// gf_log_seq_if
// Request/response handshake bundle of the GF(2^8) discrete-log unit.
//   valid_i / ready_o / elem_i   request side (element to take the log of)
//   valid_o / ready_i / idx_o / err_o   result side
// Modports:
//   slave  - the log unit itself
//   master - whoever issues requests and consumes results
// -----------------------------------------------------------------------------
interface gf_log_seq_if;
    import gf_pkg::*;

    logic     valid_i;
    logic     ready_o;
    gf_elem_t elem_i;
    logic     valid_o;
    logic     ready_i;
    gf_elem_t idx_o;
    logic     err_o;

    modport slave (
        input  valid_i,
        input  elem_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output idx_o,
        output err_o
    );

    modport master (
        output valid_i,
        output elem_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  idx_o,
        input  err_o
    );

endinterface

// File: rtl/gf_log_seq.sv
// -----------------------------------------------------------------------------
// gf_log_seq
// Sequential discrete-log unit for GF(2^8). For a nonzero element e it returns
// the smallest idx in 0..254 with e == x^(-idx) mod POLY, i.e. the position of
// e in the degree LUT. The search walks the powers of x^-1 starting at 1, one
// field step and one comparison per clock, so no table is stored.
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset
//   bus     gf_log_seq_if.slave
//             valid_i/ready_o/elem_i : request, accepted only in IDLE
//             valid_o/ready_i        : result handshake, held while stalled
//             idx_o                  : log index 0..254
//             err_o                  : element was 0 (or search exhausted)
// Latency from the accept edge to the edge that first samples valid_o high:
// idx+2 for nonzero elements, 1 for element 0.
// -----------------------------------------------------------------------------
module gf_log_seq
    import gf_pkg::*;
#(
    parameter logic [8:0] POLY = GF_POLY
) (
    input  logic          clk_i,
    input  logic          rst_i,
    gf_log_seq_if.slave   bus
);

    localparam logic [1:0] S_IDLE   = GF_LOG_IDLE;
    localparam logic [1:0] S_SEARCH = GF_LOG_SEARCH;
    localparam logic [1:0] S_DONE   = GF_LOG_DONE;

    // Highest index a primitive polynomial can produce before the walk wraps.
    localparam gf_elem_t LAST_IDX = gf_elem_t'(GF_ORDER - 1);

    logic [1:0] r_state;
    gf_elem_t   r_target;
    gf_elem_t   r_cur;
    gf_elem_t   r_cnt;
    gf_elem_t   r_idx;
    logic       r_err;

    gf_elem_t   w_next;
    logic       w_hit;

    assign w_next = gf_div_x(r_cur, POLY);
    assign w_hit  = (r_cur == r_target);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_target <= '0;
            r_cur    <= 8'h01;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.valid_i) begin
                        r_target <= bus.elem_i;
                        if (bus.elem_i == '0) begin
                            // log(0) is undefined: answer immediately.
                            r_idx   <= '0;
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cur   <= 8'h01;
                            r_cnt   <= '0;
                            r_state <= S_SEARCH;
                        end
                    end
                end
                S_SEARCH: begin
                    // The hit test runs before the wrap test so that element 1
                    // resolves at idx 0 and idx 254 can still be reported.
                    if (w_hit) begin
                        r_idx   <= r_cnt;
                        r_err   <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_cnt == LAST_IDX) begin
                        // Only reachable with a non-primitive polynomial.
                        r_idx   <= 8'hFF;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cur <= w_next;
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    if (bus.ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o = (r_state == S_IDLE);
    assign bus.valid_o = (r_state == S_DONE);
    assign bus.idx_o   = r_idx;
    assign bus.err_o   = r_err;

endmodule

// File: tb/tb_gf_log_seq.sv
// -----------------------------------------------------------------------------
// tb_gf_log_seq
// Bench for the GF(2^8) discrete-log unit. The reference computes the log by
// multiplying the element by x until it reaches 1 (e * x^k == 1 <=> e == x^-k),
// which is independent of the unit's backward walk from 1.
// -----------------------------------------------------------------------------
module tb_gf_log_seq;

    localparam logic [8:0] POLY = 9'h11D;

    logic clk;
    logic rst;

    gf_log_seq_if u_if ();

    gf_log_seq #(.POLY(POLY)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] exp_idx[$];
    logic       exp_err[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Multiply by x in GF(2^8).
    function automatic logic [7:0] mul_x(input logic [7:0] v);
        logic [8:0] t;
        t = {v, 1'b0};
        if (t[8]) t = t ^ POLY;
        return t[7:0];
    endfunction

    function automatic logic [7:0] mul_xk(input logic [7:0] e, input int k);
        logic [7:0] v;
        v = e;
        for (int i = 0; i < k; i++) v = mul_x(v);
        return v;
    endfunction

    // Smallest k with e * x^k == 1; -1 for e == 0.
    function automatic int model_log(input logic [7:0] e);
        logic [7:0] v;
        if (e == 8'd0) return -1;
        v = e;
        for (int k = 0; k < 255; k++) begin
            if (v == 8'd1) return k;
            v = mul_x(v);
        end
        return -2;
    endfunction

    // Result monitor: every cycle valid_o is high the outputs must match the
    // oldest outstanding request's expectation.
    always @(negedge clk) begin
        if (rst) begin
            exp_idx.delete();
            exp_err.delete();
        end else if (u_if.valid_o) begin
            if (exp_idx.size() == 0) begin
                chk("unexpected_valid", 32'(u_if.valid_o), 32'd0);
            end else begin
                chk("mon_idx", 32'(u_if.idx_o), 32'(exp_idx[0]));
                chk("mon_err", 32'(u_if.err_o), 32'(exp_err[0]));
                chk("mon_ready_o_low", 32'(u_if.ready_o), 32'd0);
                if (u_if.ready_i) begin
                    void'(exp_idx.pop_front());
                    void'(exp_err.pop_front());
                end
            end
        end
    end

    // Issue one request, wait for the result, hold it bp cycles, then accept it.
    // lat = edges from the accept edge to the first edge that samples valid_o high.
    task automatic send(input logic [7:0] e, input int bp, output int lat,
                        output logic [7:0] got_idx, output logic got_err);
        int g;
        int m;
        g = 0;
        while (!u_if.ready_o && g < 400) begin
            @(posedge clk); #1; g++;
        end
        if (!u_if.ready_o) chk("ready_timeout", 32'(u_if.ready_o), 32'd1);
        m = model_log(e);
        exp_idx.push_back((e == 8'd0) ? 8'h00 : 8'(m));
        exp_err.push_back(e == 8'd0);
        u_if.valid_i = 1'b1;
        u_if.elem_i  = e;
        u_if.ready_i = 1'b0;
        @(posedge clk); #1;
        u_if.valid_i = 1'b0;
        u_if.elem_i  = 8'($urandom);
        lat = 1;
        while (!u_if.valid_o && lat < 400) begin
            u_if.valid_i = 1'($urandom_range(0, 1));
            u_if.elem_i  = 8'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        if (!u_if.valid_o) chk("valid_timeout", 32'(u_if.valid_o), 32'd1);
        got_idx = u_if.idx_o;
        got_err = u_if.err_o;
        for (int i = 0; i < bp; i++) begin
            u_if.valid_i = 1'($urandom_range(0, 1));
            u_if.elem_i  = 8'($urandom);
            @(posedge clk); #1;
            chk("bp_valid_held", 32'(u_if.valid_o), 32'd1);
            chk("bp_idx_stable", 32'(u_if.idx_o), 32'(got_idx));
        end
        u_if.valid_i = 1'b0;
        u_if.ready_i = 1'b1;
        @(posedge clk); #1;
        u_if.ready_i = 1'b0;
        chk("valid_drop", 32'(u_if.valid_o), 32'd0);
        chk("ready_back", 32'(u_if.ready_o), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] d_elem [7] = '{8'd1, 8'd142, 8'd71, 8'd173, 8'd128, 8'd2, 8'd0};
    int         d_idx  [7] = '{0, 1, 2, 3, 248, 254, 0};
    int         d_lat  [7] = '{2, 3, 4, 5, 250, 256, 1};
    int         d_bp   [7] = '{0, 0, 0, 10, 0, 0, 3};

    initial begin
        int         lat;
        logic [7:0] gi;
        logic       ge;
        int         m;
        int         highs;
        logic [7:0] e;

        rst          = 1'b1;
        u_if.valid_i = 1'b0;
        u_if.elem_i  = 8'h00;
        u_if.ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_o", 32'(u_if.ready_o), 32'd1);
        chk("rst_valid_o", 32'(u_if.valid_o), 32'd0);
        chk("rst_idx_o",   32'(u_if.idx_o),   32'd0);
        chk("rst_err_o",   32'(u_if.err_o),   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Pin the reference against hand-derived logs.
        for (int i = 0; i < 6; i++) begin
            chk("model_pin", 32'(model_log(d_elem[i])), 32'(d_idx[i]));
        end

        // Directed cases with literal expectations.
        for (int i = 0; i < 7; i++) begin
            send(d_elem[i], d_bp[i], lat, gi, ge);
            chk("dir_idx", 32'(gi), 32'(d_idx[i]));
            chk("dir_err", 32'(ge), (d_elem[i] == 8'd0) ? 32'd1 : 32'd0);
            chk("dir_lat", 32'(lat), 32'(d_lat[i]));
        end

        // Every nonzero element.
        for (int k = 1; k < 256; k++) begin
            e = 8'(k);
            send(e, 0, lat, gi, ge);
            m = model_log(e);
            chk("exh_lat", 32'(lat), 32'(m + 2));
            chk("exh_lut", 32'(mul_xk(e, int'(gi))), 32'd1);
        end

        // Random elements with random backpressure.
        for (int k = 0; k < 30; k++) begin
            e = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            send(e, int'($urandom_range(0, 10)), lat, gi, ge);
            m = model_log(e);
            chk("rnd_lat", 32'(lat), (e == 8'd0) ? 32'd1 : 32'(m + 2));
        end

        // Reset 50 cycles into a search for element 2: the request is dropped.
        u_if.valid_i = 1'b1;
        u_if.elem_i  = 8'd2;
        @(posedge clk); #1;
        u_if.valid_i = 1'b0;
        repeat (50) begin @(posedge clk); #1; end
        chk("mid_search_busy", 32'(u_if.ready_o), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_ready", 32'(u_if.ready_o), 32'd1);
        chk("post_rst_valid", 32'(u_if.valid_o), 32'd0);
        chk("post_rst_idx",   32'(u_if.idx_o),   32'd0);
        chk("post_rst_err",   32'(u_if.err_o),   32'd0);
        highs = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (u_if.valid_o) highs++;
        end
        chk("rst_dropped_valid", 32'(highs), 32'd0);
        send(8'd71, 2, lat, gi, ge);
        chk("after_rst_idx", 32'(gi), 32'd2);
        chk("after_rst_err", 32'(ge), 32'd0);
        chk("after_rst_lat", 32'(lat), 32'd4);

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_idx.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
